// File: rtl/if_id_reg_pkg.sv
// Shared constants and types for the IF/ID pipeline register of the MIPS P7 core.
// Holds the reset/exception PCs, the bubble instruction word and the valid-state encoding.
package if_id_reg_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
    localparam logic [4:0]  EXC_NONE     = 5'd0;
    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    // The valid bit is the state register itself.
    typedef enum logic {
        BUBBLE = 1'b0,
        VALID  = 1'b1
    } vstate_t;

endpackage

// File: rtl/if_id_reg.sv
// IF->ID pipeline register: 1-cycle capture with req > stall > flush > load priority.
// Optional macro IF_ID_STALL_CNT_EN adds a free-running stall counter output ID_StallCnt.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_Instr,
    input  logic        IF_BD,
    input  logic [4:0]  IF_ExcCode,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_Instr,
    output logic        ID_BD,
    output logic [4:0]  ID_ExcCode,
    output logic        ID_Valid
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0] ID_StallCnt
`endif
);

    vstate_t     state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        bd_reg, bd_next;
    logic [4:0]  exc_reg, exc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= BUBBLE;
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_WORD;
            bd_reg    <= 1'b0;
            exc_reg   <= EXC_NONE;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            bd_reg    <= bd_next;
            exc_reg   <= exc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        bd_next    = bd_reg;
        exc_next   = exc_reg;
        if (req) begin
            state_next = BUBBLE;
            pc_next    = EXC_PC;
            instr_next = NOP_WORD;
            bd_next    = 1'b0;
            exc_next   = EXC_NONE;
        end else if (stall) begin
            // Hold everything; a pending flush waits until the stall clears.
        end else if (flush) begin
            state_next = BUBBLE;
            pc_next    = IF_PC;
            instr_next = NOP_WORD;
            bd_next    = 1'b0;
            exc_next   = EXC_NONE;
        end else begin
            // A faulting fetch still reaches CP0 with its PC, BD and code, but never decodes.
            state_next = VALID;
            pc_next    = IF_PC;
            instr_next = (IF_ExcCode == EXC_NONE) ? IF_Instr : NOP_WORD;
            bd_next    = IF_BD;
            exc_next   = IF_ExcCode;
        end
    end

    assign ID_PC      = pc_reg;
    assign ID_Instr   = instr_reg;
    assign ID_BD      = bd_reg;
    assign ID_ExcCode = exc_reg;
    assign ID_Valid   = (state_reg == VALID);

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (stall && !req) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign ID_StallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus randomized traffic against a rule-level model.
// Build with IF_ID_STALL_CNT_EN defined to also check the stall counter.
module tb_if_id_reg;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_PC  = 32'h0000_4180;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [4:0]  ADEL    = 5'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] IF_PC = 32'h0, IF_Instr = 32'h0;
    logic        IF_BD = 1'b0;
    logic [4:0]  IF_ExcCode = 5'd0;
    logic [31:0] ID_PC, ID_Instr;
    logic        ID_BD, ID_Valid;
    logic [4:0]  ID_ExcCode;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] ID_StallCnt;
    logic [31:0] e_cnt;
`endif

    // Expected architectural view of the ID stage.
    logic [31:0] e_pc, e_instr;
    logic        e_bd, e_valid;
    logic [4:0]  e_exc;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_reg dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
        .IF_PC(IF_PC), .IF_Instr(IF_Instr), .IF_BD(IF_BD), .IF_ExcCode(IF_ExcCode),
        .ID_PC(ID_PC), .ID_Instr(ID_Instr), .ID_BD(ID_BD), .ID_ExcCode(ID_ExcCode),
        .ID_Valid(ID_Valid)
`ifdef IF_ID_STALL_CNT_EN
        , .ID_StallCnt(ID_StallCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] dut_bundle();
        return {ID_PC, ID_Instr, ID_BD, ID_ExcCode, ID_Valid};
    endfunction

    function automatic logic [70:0] exp_bundle();
        return {e_pc, e_instr, e_bd, e_exc, e_valid};
    endfunction

    task automatic model_reset();
        e_pc = RST_PC; e_instr = NOP; e_bd = 1'b0; e_exc = 5'd0; e_valid = 1'b0;
`ifdef IF_ID_STALL_CNT_EN
        e_cnt = 32'd0;
`endif
    endtask

    // What the ID stage should hold after the coming edge, given the current inputs.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
`ifdef IF_ID_STALL_CNT_EN
            if (stall && !req) e_cnt = e_cnt + 32'd1;
`endif
            if (req) begin
                e_pc = EXC_PC; e_instr = NOP; e_bd = 1'b0; e_exc = 5'd0; e_valid = 1'b0;
            end else if (stall) begin
                // hold
            end else if (flush) begin
                e_pc = IF_PC; e_instr = NOP; e_bd = 1'b0; e_exc = 5'd0; e_valid = 1'b0;
            end else begin
                e_pc = IF_PC; e_bd = IF_BD; e_exc = IF_ExcCode; e_valid = 1'b1;
                e_instr = (IF_ExcCode == 5'd0) ? IF_Instr : NOP;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] pc,
                         input logic [31:0] ins, input logic bd, input logic [4:0] exc);
        req = r; stall = s; flush = f; IF_PC = pc; IF_Instr = ins; IF_BD = bd; IF_ExcCode = exc;
    endtask

    // Inputs are set after a falling edge; this advances through one rising edge to the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (dut_bundle() !== exp_bundle())
            $display("FAIL reset: got %h want %h", dut_bundle(), exp_bundle());
        if (dut_bundle() !== exp_bundle()) n_bad++;
        n_cmp++;
        if (ID_PC !== 32'h0000_3000) begin
            n_bad++;
            $display("FAIL reset_pc: got %h want 00003000", ID_PC);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_load();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h2401_0001, 1'b1, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL load: got %h want %h", dut_bundle(), exp_bundle());
        end
        n_cmp++;
        if ({ID_PC, ID_Instr, ID_BD, ID_Valid} !== {32'h0000_3004, 32'h2401_0001, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL load_literal: got pc=%h instr=%h bd=%b v=%b", ID_PC, ID_Instr, ID_BD, ID_Valid);
        end
        $display("load pc=%h instr=%h", ID_PC, ID_Instr);
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'h1111_2222, 1'b0, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0000_300C, 32'h3333_4444, 1'b0, 5'd0);
            tick();
            n_cmp++;
            if (dut_bundle() !== exp_bundle() || ID_PC !== 32'h0000_3008) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got pc=%h want 00003008", i, ID_PC);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0000_300C, 32'h3333_4444, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || ID_PC !== 32'h0000_300C) begin
            n_bad++;
            $display("FAIL stall_release: got pc=%h want 0000300c", ID_PC);
        end
        $display("stall released pc=%h", ID_PC);
    endtask

    task automatic test_fault();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 1'b0, ADEL);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() ||
            {ID_PC, ID_Instr, ID_ExcCode, ID_Valid} !== {32'h0000_3002, 32'h0, ADEL, 1'b1}) begin
            n_bad++;
            $display("FAIL fault: got pc=%h instr=%h exc=%0d v=%b", ID_PC, ID_Instr, ID_ExcCode, ID_Valid);
        end
        $display("fault pc=%h exc=%0d", ID_PC, ID_ExcCode);
    endtask

    task automatic test_priority();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'hAAAA_0001, 1'b1, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_3014, 32'hAAAA_0002, 1'b1, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || {ID_PC, ID_Instr, ID_Valid} !== {EXC_PC, NOP, 1'b0}) begin
            n_bad++;
            $display("FAIL req_prio: got pc=%h instr=%h v=%b", ID_PC, ID_Instr, ID_Valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0000_4180, 32'hBBBB_0001, 1'b0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h0000_4184, 32'hBBBB_0002, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || ID_Valid !== 1'b1 || ID_PC !== 32'h0000_4180) begin
            n_bad++;
            $display("FAIL stall_over_flush: got pc=%h v=%b", ID_PC, ID_Valid);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0000_4184, 32'hBBBB_0002, 1'b1, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || {ID_PC, ID_Instr, ID_BD, ID_Valid} !== {32'h0000_4184, NOP, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL flush: got pc=%h instr=%h bd=%b v=%b", ID_PC, ID_Instr, ID_BD, ID_Valid);
        end
        $display("priority checks done pc=%h", ID_PC);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'hCAFE_F00D, 1'b1, 5'd0);
        tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_bundle() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", dut_bundle(), exp_bundle());
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_5004, 32'h1234_5678, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL reset_dominates: got %h want %h", dut_bundle(), exp_bundle());
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_5008, 32'h1234_5678, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || ID_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_after_reset: got v=%b pc=%h", ID_Valid, ID_PC);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0000_500C, 32'h8765_4321, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (dut_bundle() !== exp_bundle() || ID_Valid !== 1'b1) begin
            n_bad++;
            $display("FAIL first_load: got v=%b pc=%h", ID_Valid, ID_PC);
        end
        $display("mid-run reset done");
    endtask

`ifdef IF_ID_STALL_CNT_EN
    task automatic test_stall_cnt();
        logic [31:0] base;
        base = ID_StallCnt;
        for (int i = 0; i < 5; i++) begin
            drive((i == 2), 1'b1, 1'b0, 32'h0000_6000, 32'h0, 1'b0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0000_6004, 32'h0, 1'b0, 5'd0);
        tick();
        n_cmp++;
        if (ID_StallCnt - base !== 32'd4 || ID_StallCnt !== e_cnt) begin
            n_bad++;
            $display("FAIL stall_cnt: got delta=%0d want 4", ID_StallCnt - base);
        end
        $display("stall counter delta=%0d", ID_StallCnt - base);
    endtask
`endif

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  $urandom, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
            tick();
            n_cmp++;
            if (dut_bundle() !== exp_bundle()) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got %h want %h", i, dut_bundle(), exp_bundle());
            end
`ifdef IF_ID_STALL_CNT_EN
            n_cmp++;
            if (ID_StallCnt !== e_cnt) begin
                n_bad++;
                $display("FAIL random_cnt[%0d]: got %0d want %0d", i, ID_StallCnt, e_cnt);
            end
`endif
        end
        $display("random: 300 cycles, %0d bundle errors", errs);
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_fault();
        test_priority();
        test_reset_mid();
`ifdef IF_ID_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the IF stage and the ID stage of the 5-stage MIPS P7 core.
- Captures the fetch-side bundle each cycle: PC, instruction word, delay-slot flag and fetch exception code.
- Holds the bundle under stall, inserts bubbles on flush, and redirects to the exception entry when an interrupt/exception request arrives.
- Tracks a valid bit so ID never decodes a squashed or faulting fetch as a real instruction.

Parameters:
- RESET_PC, 32'h0000_3000, value of ID_PC after reset.
- EXC_PC, 32'h0000_4180, PC reported by the bubble inserted on req (macroscopic-PC continuity).
- NOP_WORD, 32'h0000_0000, instruction word driven for any bubble or faulting fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  interrupt/exception request from CP0; flushes the stage.
- stall  in  1  hazard-unit stall for ID; holds the register.
- flush  in  1  ERET / squash from ID; inserts a bubble.
- IF_PC  in  32  fetch PC.
- IF_Instr  in  32  instruction word for IF_PC.
- IF_BD  in  1  IF instruction is in a delay slot.
- IF_ExcCode  in  5  fetch exception code (0 = none, AdEL on misaligned or out-of-range PC).
- ID_PC  out  32  registered PC.
- ID_Instr  out  32  registered instruction; NOP_WORD when not valid or when faulting.
- ID_BD  out  1  registered delay-slot flag.
- ID_ExcCode  out  5  registered exception code.
- ID_Valid  out  1  ID holds a real fetched instruction.

Behaviour:
- Reset asserted (reset=0), asynchronous, at any time:
  - ID_PC=RESET_PC, ID_Instr=NOP_WORD, ID_BD=0, ID_ExcCode=0, ID_Valid=0.
  - The stall counter, if present, clears.
- Deassertion takes effect at the next rising edge.
- Update priority at each rising edge: req > stall > flush > load.
- req=1:
  - ID_PC=EXC_PC, ID_Instr=NOP_WORD, ID_BD=0, ID_ExcCode=0, ID_Valid=0.
  - stall and flush are ignored in that cycle.
- stall=1 (req=0): all outputs hold their values; flush is ignored (ERET cannot be flushed while it is itself stalled).
- flush=1 (req=0, stall=0):
  - ID_PC=IF_PC, ID_Instr=NOP_WORD, ID_BD=0, ID_ExcCode=0, ID_Valid=0.
  - PC is kept for macroscopic-PC reporting.
- load (none of the above):
  - ID_PC=IF_PC, ID_BD=IF_BD, ID_ExcCode=IF_ExcCode, ID_Valid=1.
  - ID_Instr=IF_Instr if IF_ExcCode==0, else NOP_WORD. A faulting fetch still carries the PC, BD and code to CP0.
- Latency: exactly 1 cycle IF→ID. No combinational path from any input to any output.
- Valid-state FSM, two states encoded by ID_Valid:
  - BUBBLE→VALID on load.
  - VALID→BUBBLE on req or flush.
  - Either state self-loops on stall.
- Repeated stall of any length is lossless; the held bundle is released on the first cycle with stall=0.
- req during reset deassertion edge: reset dominates.

Optional Feature:
- Macro IF_ID_STALL_CNT_EN.
- Defined:
  - Extra output ID_StallCnt (32 bits).
  - Increments by 1 on every rising edge with stall=1 and req=0; wraps 32'hFFFF_FFFF→0.
  - Cleared by reset.
  - Unaffected by flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- constants.v (shared):
  - AdEL exception code.
  - EXC_PC value 32'h4180.
  - NOP_WORD.
  - RESET_PC.
- Single module; no sub-module is natural. The optional counter stays inline under the macro.

Test Plan:
- Reset mid-run: drive a valid load, pull reset=0 between edges → outputs immediately PC=0x3000, Instr=0, Valid=0, Exc=0; Valid stays 0 until the first load after release.
- Normal load: IF_PC=0x3004, IF_Instr=0x24010001, BD=1, Exc=0 → next edge ID_PC=0x3004, ID_Instr=0x24010001, ID_BD=1, ID_Valid=1.
- Stall hold: load 0x3008, then stall=1 for 3 cycles while IF_PC changes to 0x300C → ID_PC stays 0x3008 for all 3 cycles; 0x300C appears one edge after stall drops.
- Faulting fetch: IF_PC=0x3002, IF_Instr=0xFFFFFFFF, Exc=AdEL → ID_PC=0x3002, ID_Instr=0, ID_ExcCode=AdEL, ID_Valid=1.
- Priority, req vs stall and flush: req=1 with stall=1 and flush=1 → ID_PC=0x4180, Instr=0, Valid=0. Then stall=1 and flush=1 with req=0 → hold; flush takes effect only once stall drops, giving ID_PC=IF_PC, Valid=0.
- With IF_ID_STALL_CNT_EN defined: 5 stall cycles, one of them coinciding with req → ID_StallCnt=4.
